// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   ldr_state_t    : loader FSM states
//   BYTES_PER_WORD : stream bytes packed into one instruction
//   WORD_STRIDE    : byte-address increment between consecutive words
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } ldr_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_STRIDE    = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream big-endian into 32-bit words (first byte lands in [31:24]).
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   byte_in    : stream byte
//   accept     : byte_in is taken on this edge
//   clear      : discard any partial word and restart at byte 0
//   word       : packed word including the byte currently offered
//   word_full  : accept of the last byte of a word this cycle
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_full
);

    // Only the first three bytes need storage; the fourth is taken straight
    // from byte_in so the complete word is available on the accepting edge.
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            shift_q <= {shift_q[15:0], byte_in};
            cnt_q   <= cnt_q + 2'd1;   // wraps to 0 after the last byte
        end
    end

    assign word      = {shift_q, byte_in};
    assign word_full = accept && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader for the IF stage instruction-memory write port.
// Receives bytes over a valid/ready stream, packs them big-endian into words
// and writes them to consecutive addresses starting at BASE_ADDR, holding the
// core in reset until the whole image is written.
// Ports:
//   CLK, RST        : clock and synchronous active-high reset
//   Start, Len      : session request and word count (sampled in IDLE only)
//   Bdata, Bvalid   : stream byte and its valid
//   Bready          : loader takes a byte this cycle
//   newPC, W_Ins, WE: IF write address, instruction word and write enable
//   CPU_RST         : reset to the core
//   Busy            : session in progress
//   Done            : pulse in the cycle after the last word is written
//   Err             : pulse after a rejected Start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [15:0] Len,
    input  logic [7:0]  Bdata,
    input  logic        Bvalid,
    output logic        Bready,
    output logic [31:0] newPC,
    output logic [31:0] W_Ins,
    output logic        WE,
    output logic        CPU_RST,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    ldr_state_t  state_q, state_d;
    logic [15:0] len_q;
    logic [15:0] word_cnt_q;
    logic [31:0] addr_q;
    logic [31:0] new_pc_q;
    logic [31:0] w_ins_q;
    logic        err_q;

    logic        len_ok;
    logic        start_ok;
    logic        start_bad;
    logic        accept;
    logic        last_word;
    logic [31:0] pk_word;
    logic        pk_full;

    // Len in 1..MAX_WORDS keeps addr inside the memory, so addr never wraps.
    assign len_ok    = (Len != 16'd0) && ({16'd0, Len} <= MAX_WORDS);
    assign start_ok  = (state_q == IDLE) && Start && len_ok;
    assign start_bad = (state_q == IDLE) && Start && !len_ok;
    assign accept    = (state_q == RECV) && Bvalid;
    assign last_word = ((word_cnt_q + 16'd1) == len_q);

    byte_packer u_packer (
        .clk       (CLK),
        .rst       (RST),
        .byte_in   (Bdata),
        .accept    (accept),
        .clear     (start_ok),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = RECV;
            RECV:    if (pk_full) state_d = WRITE;
            WRITE:   state_d = last_word ? FIN : RECV;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= BASE_ADDR;
            new_pc_q   <= '0;
            w_ins_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= start_bad;
            if (start_ok) begin
                len_q      <= Len;
                addr_q     <= BASE_ADDR;
                word_cnt_q <= '0;
            end
            // Capture the write port on entry to WRITE; it then holds its
            // last written value until the next word is complete.
            if (pk_full) begin
                new_pc_q <= addr_q;
                w_ins_q  <= pk_word;
            end
            if (state_q == WRITE) begin
                addr_q     <= addr_q + WORD_STRIDE;
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

    assign Bready  = (state_q == RECV);
    assign WE      = (state_q == WRITE);
    assign Done    = (state_q == FIN);
    assign Busy    = (state_q != IDLE);
    assign CPU_RST = RST || (state_q != IDLE);
    assign newPC   = new_pc_q;
    assign W_Ins   = w_ins_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int unsigned MAX_W = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [7:0]  bdata;
    logic        bvalid;
    logic        bready;
    logic [31:0] new_pc;
    logic [31:0] w_ins;
    logic        we;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAX_W)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .Start   (start),
        .Len     (len),
        .Bdata   (bdata),
        .Bvalid  (bvalid),
        .Bready  (bready),
        .newPC   (new_pc),
        .W_Ins   (w_ins),
        .WE      (we),
        .CPU_RST (cpu_rst),
        .Busy    (busy),
        .Done    (done),
        .Err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the IF instruction memory and the byte image being streamed.
    logic [31:0] imem [MAX_W];
    logic [7:0]  bytes [$];
    logic [31:0] last_we_addr;

    typedef struct {
        logic [15:0] len;
        logic        exp_err;
        logic        exp_busy;
    } start_vec_t;

    start_vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int k);
        return {bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]};
    endfunction

    task automatic fill_bytes(input int n);
        bytes.delete();
        for (int i = 0; i < 4 * n; i++) bytes.push_back(8'($urandom));
    endtask

    // Stream bytes[] into the loader as an n-word session.
    // mode 0: Bvalid steady, 1: every other cycle, 2: random.
    task automatic run_load(input int n, input int mode, input bit inject, input bit timing);
        int  idx, it, done_it, we_cnt, err_cnt, limit, wi;
        bit  hs, v, done_seen, rdy_ok;
        idx = 0; we_cnt = 0; err_cnt = 0; done_seen = 0; done_it = -1; rdy_ok = 1;
        limit = 40 * n + 40;
        start = 1'b1;
        len = 16'(n);
        bvalid = 1'b0;
        cyc();
        start = 1'b0;
        it = 1;
        chk("recv_bready", bready, 1'b1);
        chk("recv_busy", busy, 1'b1);
        while (!done_seen && it < limit) begin
            if (we) begin
                if (bready) rdy_ok = 0;
                if (we_cnt < n) begin
                    chk("we_addr", new_pc, BASE + 32'(4 * we_cnt));
                    chk("we_data", w_ins, exp_word(we_cnt));
                end else begin
                    chk("extra_we", 32'(we_cnt), 32'(n));
                end
                wi = int'((new_pc - BASE) >> 2);
                if (wi >= 0 && wi < int'(MAX_W)) imem[wi] = w_ins;
                last_we_addr = new_pc;
                we_cnt++;
            end
            if (err) err_cnt++;
            if (done) begin
                done_seen = 1;
                done_it = it;
                chk("cpu_rst_at_done", cpu_rst, 1'b1);
                break;
            end
            start = 1'b0;
            if (inject && it == 3) begin
                start = 1'b1;
                len = 16'd5;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = it[0];
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bvalid = (idx < 4 * n) && v;
            bdata = bvalid ? bytes[idx] : 8'($urandom);
            hs = bvalid && bready;
            cyc();
            if (hs) idx++;
            it++;
        end
        start = 1'b0;
        bvalid = 1'b0;
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("we_count", 32'(we_cnt), 32'(n));
        chk("no_err_in_session", 32'(err_cnt), 32'd0);
        chk("bready_low_in_write", 32'(rdy_ok), 32'd1);
        chk("bytes_consumed", 32'(idx), 32'(4 * n));
        if (timing) chk("done_latency", 32'(done_it), 32'(5 * n + 1));
        cyc();
        chk("cpu_rst_release", cpu_rst, 1'b0);
        chk("done_pulse", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int idx, it, we_cnt;
        bit hs;
        rst = 1'b1; start = 1'b0; len = '0; bdata = '0; bvalid = 1'b0;
        last_we_addr = '0;
        for (int i = 0; i < int'(MAX_W); i++) imem[i] = '0;

        // Reset values
        cyc(); cyc();
        chk("rst_bready", bready, 1'b0);
        chk("rst_newpc", new_pc, 32'h0);
        chk("rst_wins", w_ins, 32'h0);
        chk("rst_we", we, 1'b0);
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        #1;
        chk("idle_cpu_rst", cpu_rst, 1'b0);

        // Start acceptance / rejection table
        vecs[0] = '{16'd0,              1'b1, 1'b0};
        vecs[1] = '{16'(MAX_W + 1),     1'b1, 1'b0};
        vecs[2] = '{16'hFFFF,           1'b1, 1'b0};
        vecs[3] = '{16'd1,              1'b0, 1'b1};
        vecs[4] = '{16'(MAX_W),         1'b0, 1'b1};
        foreach (vecs[i]) begin
            start = 1'b1;
            len = vecs[i].len;
            cyc();
            start = 1'b0;
            chk("tbl_err", err, vecs[i].exp_err);
            chk("tbl_busy", busy, vecs[i].exp_busy);
            chk("tbl_bready", bready, vecs[i].exp_busy);
            chk("tbl_cpu_rst", cpu_rst, vecs[i].exp_busy);
            chk("tbl_we", we, 1'b0);
            cyc();
            chk("tbl_err_pulse", err, 1'b0);
            if (vecs[i].exp_busy) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                #1;
                chk("tbl_abort_busy", busy, 1'b0);
            end
        end

        // Single-word load with known bytes
        bytes.delete();
        bytes.push_back(8'h00); bytes.push_back(8'h22);
        bytes.push_back(8'h18); bytes.push_back(8'h20);
        run_load(1, 0, 1'b0, 1'b1);
        chk("single_addr", last_we_addr, 32'h0);
        chk("single_mem", imem[0], 32'h0022_1820);

        // Multi-word load with bubbles
        fill_bytes(3);
        run_load(3, 1, 1'b0, 1'b0);

        // Start while busy is ignored
        fill_bytes(2);
        run_load(2, 0, 1'b1, 1'b1);

        // Reset mid-session after byte 6
        fill_bytes(2);
        start = 1'b1; len = 16'd2;
        cyc();
        start = 1'b0;
        idx = 0; it = 0; we_cnt = 0;
        while (idx < 6 && it < 100) begin
            bvalid = 1'b1;
            bdata = bytes[idx];
            hs = bready;
            cyc();
            if (hs) idx++;
            if (we) begin
                we_cnt++;
                imem[0] = w_ins;
            end
            it++;
        end
        chk("mid_bytes", 32'(idx), 32'd6);
        chk("mid_we_before", 32'(we_cnt), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_cpu_rst_in_rst", cpu_rst, 1'b1);
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_bready", bready, 1'b0);
        chk("mid_cpu_rst", cpu_rst, 1'b0);
        we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            bvalid = 1'b1;
            bdata = 8'($urandom);
            cyc();
            if (we) we_cnt++;
        end
        bvalid = 1'b0;
        chk("mid_no_we_after", 32'(we_cnt), 32'd0);
        chk("mid_kept_word0", imem[0], exp_word(0));
        fill_bytes(1);
        run_load(1, 0, 1'b0, 1'b1);
        chk("fresh_addr", last_we_addr, 32'h0);

        // Full capacity
        fill_bytes(int'(MAX_W));
        run_load(int'(MAX_W), 0, 1'b0, 1'b1);
        chk("full_last_addr", last_we_addr, BASE + 32'(4 * (MAX_W - 1)));
        chk("full_fetch_last", imem[MAX_W - 1], exp_word(int'(MAX_W) - 1));

        // Randomized loads
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, MAX_W));
            fill_bytes(n);
            run_load(n, 2, 1'b0, 1'b0);
            for (int k = 0; k < n; k++) chk("rand_mem", imem[k], exp_word(k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
